ifu_rvc_aligner: RTL and testbench

- Instruction-fetch realigner that sits directly downstream of the fetch-word fifo_simple.
- Consumes 32-bit aligned fetch words from the FIFO read port and emits one RISC-V instruction per handshake, either 16-bit compressed (RVC) or 32-bit.
- Handles 32-bit instructions that straddle two fetch words, and redirects to halfword-aligned PCs.
- Feeds the decode stage over a valid/ready handshake.

---
 rtl/ifu_rvc_aligner.sv | 122 ++++++++++++
 tb/tb_ifu_rvc_aligner.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ifu_rvc_aligner.sv
// ifu_rvc_aligner: realigns 32-bit fetch words from the fetch FIFO into a
// stream of 16-bit (RVC) and 32-bit RISC-V instructions for decode.
// Straddling 32-bit instructions are assembled from a held upper halfword.
module ifu_rvc_aligner #(
   parameter int              PC_W     = 32,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fifo_unempty,
   input  logic [31:0]     fifo_data,
   output logic            fifo_r_req,
   input  logic            flush,
   input  logic [PC_W-1:0] flush_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [PC_W-1:0] inst_pc,
   output logic            inst_is_rvc
);

   typedef struct packed {
      logic [PC_W-1:0] pc;      // PC of the next instruction to emit
      logic            off;     // next halfword within head word (1 = upper)
      logic            hold_v;  // upper half of a straddling inst is held
      logic [15:0]     hold;
   } state_t;

   state_t          st_q, st_d;
   logic [15:0]     lo, hi;
   logic            lo_rvc, hi_rvc;
   logic            pop_on_fire;   // accepted inst ends in the head word's upper half
   logic            load_hold;     // upper half starts a straddling inst
   logic            fire;
   logic [PC_W-1:0] pc_p2, pc_p4;

   assign lo     = fifo_data[15:0];
   assign hi     = fifo_data[31:16];
   assign lo_rvc = (lo[1:0] != 2'b11);
   assign hi_rvc = (hi[1:0] != 2'b11);
   assign pc_p2  = st_q.pc + PC_W'(2);
   assign pc_p4  = st_q.pc + PC_W'(4);

   // Select the instruction at the current halfword; inst_ready is not used
   // here so inst_valid never depends on it.
   always_comb begin
      inst_valid  = 1'b0;
      inst        = fifo_data;
      inst_is_rvc = 1'b0;
      pop_on_fire = 1'b0;
      load_hold   = 1'b0;
      if (st_q.hold_v) begin
         inst_valid = fifo_unempty;
         inst       = {lo, st_q.hold};
      end else if (!st_q.off) begin
         inst_valid = fifo_unempty;
         if (lo_rvc) begin
            inst        = {16'h0, lo};
            inst_is_rvc = 1'b1;
         end else begin
            inst        = fifo_data;
            pop_on_fire = 1'b1;
         end
      end else if (hi_rvc) begin
         inst_valid  = fifo_unempty;
         inst        = {16'h0, hi};
         inst_is_rvc = 1'b1;
         pop_on_fire = 1'b1;
      end else begin
         // straddle: stash the upper half and pop, no instruction this cycle
         load_hold = fifo_unempty;
      end
      if (flush) begin
         inst_valid = 1'b0;
         load_hold  = 1'b0;
      end
   end

   assign fire       = inst_valid & inst_ready;
   assign fifo_r_req = (fire & pop_on_fire) | load_hold;
   assign inst_pc    = st_q.pc;

   // Next state: flush over fire over hold load.
   always_comb begin
      st_d = st_q;
      if (flush) begin
         st_d.pc     = flush_pc;
         st_d.off    = flush_pc[1];
         st_d.hold_v = 1'b0;
      end else if (fire) begin
         if (st_q.hold_v) begin
            st_d.hold_v = 1'b0;
            st_d.off    = 1'b1;
            st_d.pc     = pc_p4;
         end else if (!st_q.off) begin
            if (lo_rvc) begin
               st_d.off = 1'b1;
               st_d.pc  = pc_p2;
            end else begin
               st_d.pc  = pc_p4;
            end
         end else begin
            st_d.off = 1'b0;
            st_d.pc  = pc_p2;
         end
      end else if (load_hold) begin
         st_d.hold   = hi;
         st_d.hold_v = 1'b1;
         st_d.off    = 1'b0;
      end
   end

   // State register with synchronous active-low reset; a held half is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q <= '{pc: RESET_PC, off: RESET_PC[1], hold_v: 1'b0, hold: 16'h0};
      end else begin
         st_q <= st_d;
      end
   end

endmodule

// File: tb/tb_ifu_rvc_aligner.sv
// Randomized bench for ifu_rvc_aligner. The reference model keeps the fetch
// stream as a queue of halfwords and parses RISC-V instruction lengths from it.
module tb_ifu_rvc_aligner;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst, fifo_unempty, fifo_r_req, flush, inst_valid, inst_ready, inst_is_rvc;
   logic [31:0] fifo_data, flush_pc, inst, inst_pc;

   always #5 clk = ~clk;

   ifu_rvc_aligner #(.PC_W(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .fifo_unempty(fifo_unempty), .fifo_data(fifo_data),
      .fifo_r_req(fifo_r_req), .flush(flush), .flush_pc(flush_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
      .inst_pc(inst_pc), .inst_is_rvc(inst_is_rvc)
   );

   typedef struct {
      logic [15:0] hw;
      bit          hi;   // came from the upper half of its fetch word
   } hw_t;

   logic [31:0] src[$];   // words not yet visible at the FIFO
   logic [31:0] fq[$];    // FIFO contents, head = fq[0]
   hw_t         hwq[$];   // halfwords still to be turned into instructions
   logic [31:0] m_pc;
   bit          held, seg_first, seg_off;
   int          n_cmp = 0, n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit is_rvc(input logic [15:0] h);
      return h[1:0] != 2'b11;
   endfunction

   function automatic logic [15:0] rand_hw();
      logic [15:0] h;
      h = 16'($urandom);
      if ($urandom_range(1) == 0) h[1:0] = 2'b11;
      else if (h[1:0] == 2'b11) h[1:0] = 2'b01;
      return h;
   endfunction

   task automatic seg_start(input logic [31:0] pc);
      src.delete(); fq.delete(); hwq.delete();
      held = 0; m_pc = pc; seg_off = pc[1]; seg_first = 1;
   endtask

   task automatic feed_word();
      logic [31:0] w;
      w = src.pop_front();
      fq.push_back(w);
      if (!(seg_first && seg_off)) hwq.push_back('{hw: w[15:0], hi: 1'b0});
      hwq.push_back('{hw: w[31:16], hi: 1'b1});
      seg_first = 0;
   endtask

   // One clock: drive at negedge, check just after, advance model for the posedge.
   task automatic step(input bit do_rst, input bit do_flush, input logic [31:0] fpc, input bit rdy);
      bit          ev, ep, efire, erv;
      logic [31:0] ei;
      int          n;
      @(negedge clk);
      rst          = !do_rst;
      flush        = do_flush;
      flush_pc     = fpc;
      inst_ready   = rdy;
      fifo_unempty = (fq.size() != 0);
      fifo_data    = (fq.size() != 0) ? fq[0] : $urandom;
      #1;
      ev = 0; ep = 0; erv = 0; ei = 0; n = 0;
      if (!do_flush) begin
         if (held) begin
            if (hwq.size() >= 2) begin ev = 1; n = 2; ei = {hwq[1].hw, hwq[0].hw}; end
         end else if (hwq.size() >= 1) begin
            if (is_rvc(hwq[0].hw)) begin
               ev = 1; n = 1; erv = 1; ei = {16'h0, hwq[0].hw};
            end else if (!hwq[0].hi) begin
               ev = 1; n = 2; ei = {hwq[1].hw, hwq[0].hw};
            end else begin
               ep = 1;   // upper half starts a straddle: hold load
            end
         end
      end
      efire = ev && rdy;
      if (efire) ep = hwq[n-1].hi;
      if (!do_rst) begin
         chk("inst_valid", {31'h0, inst_valid}, {31'h0, ev});
         chk("fifo_r_req", {31'h0, fifo_r_req}, {31'h0, ep});
         if (ev) begin
            chk("inst", inst, ei);
            chk("inst_pc", inst_pc, m_pc);
            chk("inst_is_rvc", {31'h0, inst_is_rvc}, {31'h0, erv});
         end
      end
      if (do_rst) seg_start(RST_PC);
      else if (do_flush) seg_start(fpc);
      else begin
         if (ep) void'(fq.pop_front());
         if (efire) begin
            repeat (n) void'(hwq.pop_front());
            m_pc = m_pc + 32'(2 * n);
            held = 0;
         end else if (ep) begin
            held = 1;
         end
      end
      if (src.size() != 0 && fq.size() < 4 && $urandom_range(3) != 0) feed_word();
   endtask

   task automatic run(input int cycles, input int rdy_pct);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, $urandom_range(99) < rdy_pct);
   endtask

   initial begin
      logic [31:0] fpc;
      int          nw;
      rst = 0; flush = 0; flush_pc = 0; inst_ready = 0; fifo_unempty = 0; fifo_data = 0;
      seg_start(RST_PC);
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      run(3, 100);   // empty FIFO after reset: no valid, no pop

      // directed sequence from reset PC
      src.push_back(32'h0000_0013);
      src.push_back(32'h4501_4501);
      src.push_back(32'h0013_4501);
      src.push_back(32'h4501_0000);
      run(20, 100);

      // backpressure on a 32-bit word
      src.push_back(32'h0000_0013);
      while (src.size() != 0) step(0, 0, 0, 0);
      run(3, 0);
      run(3, 100);

      // flush while a half is held, then a word containing the halfword target
      src.push_back(32'h0013_4501);
      src.push_back(32'h4501_0000);
      run(4, 100);
      step(0, 1, 32'h8000_1002, 1);
      src.push_back(32'h4501_0001);
      run(6, 100);

      // reset mid-straddle
      src.push_back(32'h0013_4501);
      run(3, 100);
      step(1, 0, 0, 1);
      src.push_back(32'h0000_4501);
      run(6, 100);

      // random segments, each started by a flush or a reset
      for (int s = 0; s < 50; s++) begin
         if ($urandom_range(3) == 0) begin
            step(1, 0, 0, 1);
         end else begin
            fpc = {$urandom, 1'b0} & 32'hFFFF_FFFE;
            if ($urandom_range(4) == 0) fpc = 32'hFFFF_FFF8 | {29'h0, 2'($urandom_range(3)), 1'b0};
            step(0, 1, fpc, $urandom_range(1));
         end
         nw = $urandom_range(4, 12);
         for (int w = 0; w < nw; w++) src.push_back({rand_hw(), rand_hw()});
         run($urandom_range(20, 60), $urandom_range(30, 100));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
